// File: rtl/weight_pkg.sv
// -----------------------------------------------------------------------------
// weight_pkg
// Shared types for the weight read sequencer:
//   - wrs_state_e : sequencer FSM states (IDLE, RUN, DRAIN, DONE)
//   - WRS_PIPE_DEF: default weight_manager read latency in cycles
//   - wrs_tag_t   : tag travelling alongside each read {og, ig, last_ig, last}
// -----------------------------------------------------------------------------
package weight_pkg;

    // Default read latency of the weight_manager.
    localparam int WRS_PIPE_DEF  = 3;

    // Width of the group fields carried in the tag.
    localparam int WRS_GRP_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wrs_state_e;

    typedef struct packed {
        logic [WRS_GRP_WIDTH-1:0] og;
        logic [WRS_GRP_WIDTH-1:0] ig;
        logic                     last_ig;
        logic                     last;
    } wrs_tag_t;

endpackage

// File: rtl/wrs_tag_pipe.sv
// -----------------------------------------------------------------------------
// wrs_tag_pipe
// PIPE-deep shift register carrying a valid bit plus the read tag, so that
// the tag leaves exactly PIPE cycles after the read was issued.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : read issued this cycle
//   in_tag      : tag of the issued read
//   out_valid   : valid delayed by PIPE cycles
//   out_tag     : tag delayed by PIPE cycles
//   pending     : a tag sits in any stage other than the output stage
// -----------------------------------------------------------------------------
module wrs_tag_pipe
    import weight_pkg::*;
#(
    parameter int PIPE = WRS_PIPE_DEF
)(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    input  wrs_tag_t in_tag,
    output logic     out_valid,
    output wrs_tag_t out_tag,
    output logic     pending
);

    logic [PIPE-1:0] valid_r;
    wrs_tag_t        tag_r [PIPE];

    // Shift valid and tag one stage per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {PIPE{1'b0}};
            for (int i = 0; i < PIPE; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            valid_r[0] <= in_valid;
            tag_r[0]   <= in_tag;
            for (int i = 1; i < PIPE; i++) begin
                valid_r[i] <= valid_r[i-1];
                tag_r[i]   <= tag_r[i-1];
            end
        end
    end

    // Occupancy of the stages ahead of the output; the output stage empties
    // on the same edge the sequencer would leave DRAIN.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < PIPE - 1; i++) begin
            pending = pending | valid_r[i];
        end
    end

    assign out_valid = valid_r[PIPE-1];
    assign out_tag   = tag_r[PIPE-1];

endmodule

// File: rtl/weight_read_sequencer.sv
// -----------------------------------------------------------------------------
// weight_read_sequencer
// Walks og (outer) x rep (middle) x ig (inner) and issues one weight_manager
// read per cycle, throttled by a downstream credit counter. A tag pipeline
// returns {og, ig, last_ig, last} aligned with the read data.
// Optional build macro: WRS_READY_CHECK_EN adds err_sticky, which latches any
// cycle where data_ready disagrees with tag_valid.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start                   : job start pulse (ignored while busy)
//   cfg_co_groups           : output-channel groups (COUT/8)
//   cfg_ci_groups           : input-channel groups (CIN/8)
//   cfg_reps                : passes over ig per og
//   credit_ret              : one downstream slot freed
//   data_ready              : data valid from weight_manager
//   rd_en, rd_addr          : read strobe and address (og*ci_groups + ig)
//   tag_valid, tag_og,
//   tag_ig, tag_last_ig,
//   tag_last                : tag aligned with returned data
//   busy                    : job in progress (RUN or DRAIN)
//   done                    : one-cycle pulse at job end
//   err_sticky              : (WRS_READY_CHECK_EN only) ready/tag mismatch seen
// -----------------------------------------------------------------------------
module weight_read_sequencer
    import weight_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int GRP_WIDTH  = WRS_GRP_WIDTH,
    parameter int CREDITS    = 8,
    parameter int PIPE       = WRS_PIPE_DEF
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [GRP_WIDTH-1:0]  cfg_co_groups,
    input  logic [GRP_WIDTH-1:0]  cfg_ci_groups,
    input  logic [15:0]           cfg_reps,
    input  logic                  credit_ret,
    input  logic                  data_ready,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  tag_valid,
    output logic [GRP_WIDTH-1:0]  tag_og,
    output logic [GRP_WIDTH-1:0]  tag_ig,
    output logic                  tag_last_ig,
    output logic                  tag_last,
    output logic                  busy,
    output logic                  done
`ifdef WRS_READY_CHECK_EN
    ,
    output logic                  err_sticky
`endif
);

    localparam int CNT_W = $clog2(CREDITS + 1);

    wrs_state_e            state_r;
    wrs_state_e            state_nxt_s;

    logic [GRP_WIDTH-1:0]  co_r;
    logic [GRP_WIDTH-1:0]  ci_r;
    logic [15:0]           reps_r;
    logic [GRP_WIDTH-1:0]  og_r;
    logic [GRP_WIDTH-1:0]  ig_r;
    logic [15:0]           rep_r;
    logic [ADDR_WIDTH-1:0] og_base_r;
    logic [CNT_W-1:0]      credit_cnt_r;

    logic                  rd_en_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    wrs_tag_t              issue_tag_r;
    logic                  busy_r;
    logic                  done_r;

    logic [GRP_WIDTH-1:0]  co_s;
    logic [GRP_WIDTH-1:0]  ci_s;
    logic [15:0]           reps_s;
    logic                  cfg_ok_s;
    logic                  credit_ok_s;
    logic                  credit_dec_s;
    logic                  issue_s;
    logic                  last_ig_s;
    logic                  last_rep_s;
    logic                  last_og_s;
    logic                  last_s;
    logic                  pipe_pending_s;
    wrs_tag_t              pipe_tag_s;

    // Effective configuration: live inputs while idle (the first read issues
    // on the start edge), the latched copy once the job runs.
    always_comb begin
        if (state_r == IDLE) begin
            co_s   = cfg_co_groups;
            ci_s   = cfg_ci_groups;
            reps_s = cfg_reps;
        end else begin
            co_s   = co_r;
            ci_s   = ci_r;
            reps_s = reps_r;
        end
    end

    assign cfg_ok_s     = (cfg_co_groups != {GRP_WIDTH{1'b0}}) &&
                          (cfg_ci_groups != {GRP_WIDTH{1'b0}}) &&
                          (cfg_reps != 16'd0);
    assign credit_ok_s  = (credit_cnt_r < CNT_W'(CREDITS));
    assign credit_dec_s = credit_ret && (credit_cnt_r != {CNT_W{1'b0}});

    assign last_ig_s  = (ig_r  == (ci_s   - GRP_WIDTH'(1)));
    assign last_rep_s = (rep_r == (reps_s - 16'd1));
    assign last_og_s  = (og_r  == (co_s   - GRP_WIDTH'(1)));
    assign last_s     = last_ig_s && last_rep_s && last_og_s;

    // Next-state and issue decision
    always_comb begin
        issue_s     = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && cfg_ok_s) begin
                    issue_s = credit_ok_s;
                    // A single-read job is already complete on the start edge.
                    if (credit_ok_s && last_s) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else if (start) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                issue_s = credit_ok_s;
                if (credit_ok_s && last_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (!rd_en_r && !pipe_pending_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
            done_r  <= (state_r == DONE);
        end
    end

    // Datapath: configuration latch, loop counters, issue registers, credits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            co_r         <= {GRP_WIDTH{1'b0}};
            ci_r         <= {GRP_WIDTH{1'b0}};
            reps_r       <= 16'd0;
            og_r         <= {GRP_WIDTH{1'b0}};
            ig_r         <= {GRP_WIDTH{1'b0}};
            rep_r        <= 16'd0;
            og_base_r    <= {ADDR_WIDTH{1'b0}};
            credit_cnt_r <= {CNT_W{1'b0}};
            rd_en_r      <= 1'b0;
            rd_addr_r    <= {ADDR_WIDTH{1'b0}};
            issue_tag_r  <= '0;
        end else begin
            if ((state_r == IDLE) && start && cfg_ok_s) begin
                co_r   <= cfg_co_groups;
                ci_r   <= cfg_ci_groups;
                reps_r <= cfg_reps;
            end else begin
                co_r   <= co_r;
                ci_r   <= ci_r;
                reps_r <= reps_r;
            end

            // Issue and return in the same cycle cancel out.
            case ({issue_s, credit_dec_s})
                2'b10:   credit_cnt_r <= credit_cnt_r + CNT_W'(1);
                2'b01:   credit_cnt_r <= credit_cnt_r - CNT_W'(1);
                default: credit_cnt_r <= credit_cnt_r;
            endcase

            rd_en_r <= issue_s;
            if (issue_s) begin
                rd_addr_r           <= og_base_r + ADDR_WIDTH'(ig_r);
                issue_tag_r.og      <= WRS_GRP_WIDTH'(og_r);
                issue_tag_r.ig      <= WRS_GRP_WIDTH'(ig_r);
                issue_tag_r.last_ig <= last_ig_s;
                issue_tag_r.last    <= last_s;
                if (last_s) begin
                    // Leave the counters at zero for the next job.
                    ig_r      <= {GRP_WIDTH{1'b0}};
                    rep_r     <= 16'd0;
                    og_r      <= {GRP_WIDTH{1'b0}};
                    og_base_r <= {ADDR_WIDTH{1'b0}};
                end else if (!last_ig_s) begin
                    ig_r <= ig_r + GRP_WIDTH'(1);
                end else if (!last_rep_s) begin
                    ig_r  <= {GRP_WIDTH{1'b0}};
                    rep_r <= rep_r + 16'd1;
                end else begin
                    ig_r      <= {GRP_WIDTH{1'b0}};
                    rep_r     <= 16'd0;
                    og_r      <= og_r + GRP_WIDTH'(1);
                    og_base_r <= og_base_r + ADDR_WIDTH'(ci_s);
                end
            end else begin
                // Stalled or idle: address and position hold.
                issue_tag_r <= '0;
            end
        end
    end

    wrs_tag_pipe #(
        .PIPE      (PIPE)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_en_r),
        .in_tag    (issue_tag_r),
        .out_valid (tag_valid),
        .out_tag   (pipe_tag_s),
        .pending   (pipe_pending_s)
    );

    assign rd_en       = rd_en_r;
    assign rd_addr     = rd_addr_r;
    assign tag_og      = GRP_WIDTH'(pipe_tag_s.og);
    assign tag_ig      = GRP_WIDTH'(pipe_tag_s.ig);
    assign tag_last_ig = pipe_tag_s.last_ig;
    assign tag_last    = pipe_tag_s.last;
    assign busy        = busy_r;
    assign done        = done_r;

`ifdef WRS_READY_CHECK_EN
    logic err_r;

    // Sticky flag for returned data that does not line up with the tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | (data_ready != tag_valid);
        end
    end

    assign err_sticky = err_r;
`else
    logic unused_ready_s;
    assign unused_ready_s = data_ready;
`endif

endmodule

// File: tb/tb_weight_read_sequencer.sv
`timescale 1ns/1ps
module tb_weight_read_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: CREDITS = 8
    logic        start, credit_ret, data_ready;
    logic [7:0]  cfg_co, cfg_ci;
    logic [15:0] cfg_reps;
    logic        rd_en, tag_valid, tag_last_ig, tag_last, busy, done;
    logic [11:0] rd_addr;
    logic [7:0]  tag_og, tag_ig;
`ifdef WRS_READY_CHECK_EN
    logic        err_sticky;
`endif

    // Instance B: CREDITS = 2
    logic        b_start, b_credit_ret, b_data_ready;
    logic [7:0]  b_cfg_co, b_cfg_ci;
    logic [15:0] b_cfg_reps;
    logic        b_rd_en, b_tag_valid, b_tag_last_ig, b_tag_last, b_busy, b_done;
    logic [11:0] b_rd_addr;
    logic [7:0]  b_tag_og, b_tag_ig;
`ifdef WRS_READY_CHECK_EN
    logic        b_err_sticky;
`endif

    weight_read_sequencer #(.ADDR_WIDTH(12), .GRP_WIDTH(8), .CREDITS(8), .PIPE(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_co_groups(cfg_co), .cfg_ci_groups(cfg_ci), .cfg_reps(cfg_reps),
        .credit_ret(credit_ret), .data_ready(data_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .tag_valid(tag_valid),
        .tag_og(tag_og), .tag_ig(tag_ig), .tag_last_ig(tag_last_ig),
        .tag_last(tag_last), .busy(busy), .done(done)
`ifdef WRS_READY_CHECK_EN
        , .err_sticky(err_sticky)
`endif
    );

    weight_read_sequencer #(.ADDR_WIDTH(12), .GRP_WIDTH(8), .CREDITS(2), .PIPE(3)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .cfg_co_groups(b_cfg_co), .cfg_ci_groups(b_cfg_ci), .cfg_reps(b_cfg_reps),
        .credit_ret(b_credit_ret), .data_ready(b_data_ready),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .tag_valid(b_tag_valid),
        .tag_og(b_tag_og), .tag_ig(b_tag_ig), .tag_last_ig(b_tag_last_ig),
        .tag_last(b_tag_last), .busy(b_busy), .done(b_done)
`ifdef WRS_READY_CHECK_EN
        , .err_sticky(b_err_sticky)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a job on instance A and check every cycle against a nested-loop
    // model. Credits are returned on each tag_valid cycle, data_ready follows
    // the expected tag_valid except at cycle drop_c.
    task automatic run_job(input int co, input int ci, input int reps,
                           input bit restart, input int drop_c);
        int eo[$];
        int ei[$];
        int ea[$];
        int total;
        for (int o = 0; o < co; o++)
            for (int r = 0; r < reps; r++)
                for (int i = 0; i < ci; i++) begin
                    eo.push_back(o);
                    ei.push_back(i);
                    ea.push_back(o * ci + i);
                end
        total    = eo.size();
        cfg_co   = co[7:0];
        cfg_ci   = ci[7:0];
        cfg_reps = reps[15:0];
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int c = 0; c < total + 8; c++) begin
            bit tv;
            int k;
            tv = (c >= 3) && (c < total + 3);
            k  = c - 3;
            credit_ret = tv;
            data_ready = tv && (c != drop_c);
            if (restart && c == 2) begin
                start  = 1'b1;
                cfg_co = 8'd7;
            end else begin
                start  = 1'b0;
            end
            check_eq("rd_en", rd_en, c < total);
            if (c < total) check_eq("rd_addr", rd_addr, ea[c]);
            check_eq("tag_valid", tag_valid, tv);
            if (tv) begin
                check_eq("tag_og", tag_og, eo[k]);
                check_eq("tag_ig", tag_ig, ei[k]);
                check_eq("tag_last_ig", tag_last_ig, ei[k] == ci - 1);
                check_eq("tag_last", tag_last, k == total - 1);
            end
            check_eq("busy", busy, c <= total + 2);
            check_eq("done", done, c == total + 4);
            tick();
        end
        start      = 1'b0;
        credit_ret = 1'b0;
        data_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; credit_ret = 1'b0; data_ready = 1'b0;
        cfg_co = 8'd0; cfg_ci = 8'd0; cfg_reps = 16'd0;
        b_start = 1'b0; b_credit_ret = 1'b0; b_data_ready = 1'b0;
        b_cfg_co = 8'd0; b_cfg_ci = 8'd0; b_cfg_reps = 16'd0;

        // Reset state
        tick();
        tick();
        check_eq("rst_rd_en", rd_en, 1'b0);
        check_eq("rst_rd_addr", rd_addr, 12'd0);
        check_eq("rst_tag_valid", tag_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_b_rd_en", b_rd_en, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("idle_no_read", rd_en, 1'b0);
        end

        // co=2 ci=4 reps=1: addresses 0..7, tag_last at og=1 ig=3
        run_job(2, 4, 1, 1'b0, -1);

        // co=1 ci=3 reps=2 with a start pulse mid-job that must be ignored
        run_job(1, 3, 2, 1'b1, -1);

        // Zero ci: no reads, done two cycles after start, busy stays low
        cfg_co = 8'd1; cfg_ci = 8'd0; cfg_reps = 16'd1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_eq("zero_rd_en", rd_en, 1'b0);
            check_eq("zero_busy", busy, 1'b0);
            check_eq("zero_done", done, c == 1);
            tick();
        end

        // CREDITS=2: two reads, stall for 10 cycles, one return gives one read
        b_cfg_co = 8'd1; b_cfg_ci = 8'd8; b_cfg_reps = 16'd1;
        b_start  = 1'b1;
        tick();
        b_start  = 1'b0;
        for (int c = 0; c < 14; c++) begin
            b_credit_ret = (c == 10);
            check_eq("cr_rd_en", b_rd_en, (c < 2) || (c == 12));
            check_eq("cr_rd_addr", b_rd_addr, (c < 2) ? c : ((c < 12) ? 1 : 2));
            tick();
        end
        b_credit_ret = 1'b0;

        // Reset mid-RUN at rd_addr=5
        cfg_co = 8'd2; cfg_ci = 8'd4; cfg_reps = 16'd1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            credit_ret = (c >= 3);
            data_ready = (c >= 3);
            tick();
        end
        check_eq("mid_rd_addr", rd_addr, 12'd5);
        check_eq("mid_tag_valid", tag_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rd_en", rd_en, 1'b0);
        check_eq("arst_rd_addr", rd_addr, 12'd0);
        check_eq("arst_tag_valid", tag_valid, 1'b0);
        check_eq("arst_tag_og", tag_og, 8'd0);
        check_eq("arst_busy", busy, 1'b0);
        credit_ret = 1'b0;
        data_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("post_rst_no_read", rd_en, 1'b0);
        end
        run_job(1, 2, 1, 1'b0, -1);

`ifdef WRS_READY_CHECK_EN
        check_eq("err_clear", err_sticky, 1'b0);
        run_job(1, 2, 1, 1'b0, 4);
        check_eq("err_set", err_sticky, 1'b1);
        tick();
        tick();
        check_eq("err_hold", err_sticky, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_read_sequencer.md
WEIGHT_READ_SEQUENCER -- requirements
Module: weight_read_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 12, weight_manager address width.
- GRP_WIDTH, 8, width of the group-count and group-index fields.
- CREDITS, 8, downstream buffer slots.
- PIPE, 3, weight_manager read latency in cycles.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start pulse.
- cfg_co_groups  in  GRP_WIDTH  COUT/8.
- cfg_ci_groups  in  GRP_WIDTH  CIN/8.
- cfg_reps  in  16  passes over ig per og.
- credit_ret  in  1  one downstream slot freed.
- data_ready  in  1  from weight_manager.
- rd_en  out  1  read strobe to weight_manager.
- rd_addr  out  ADDR_WIDTH  read address.
- tag_valid  out  1  tag aligned with data_out.
- tag_og  out  GRP_WIDTH  output-channel group of the returned data.
- tag_ig  out  GRP_WIDTH  input-channel group of the returned data.
- tag_last_ig  out  1  last ig of the current pass.
- tag_last  out  1  last read of the job.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
REQ-003 The design SHALL use one clock (clk) and an asynchronous active-low reset (rst_n).

Function
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-005 IDLE->RUN on start with both group counts nonzero and cfg_reps nonzero; configuration is latched on that edge.
REQ-006 start sampled in IDLE with any count zero SHALL go IDLE->DONE, issue no reads, and pulse done on the next cycle.
REQ-007 Read order SHALL be: og 0..co-1 outer, rep 0..reps-1 middle, ig 0..ci-1 inner.
REQ-008 rd_addr SHALL equal og*ci_groups+ig, formed as og_base+ig with og_base incremented by ci_groups on og advance; no multiplier.
REQ-009 The first rd_en SHALL assert the cycle after start is sampled; with credits available, one read issues per cycle back-to-back.
REQ-010 rd_en SHALL assert only when the in-flight/credit counter is below CREDITS; counter +1 per issue, -1 per credit_ret, unchanged when both occur in one cycle, never exceeding CREDITS nor underflowing.
REQ-011 While stalled, rd_addr SHALL hold and no read is skipped or repeated.
REQ-012 RUN->DRAIN after the issue carrying tag_last; DRAIN->DONE once the tag pipeline is empty (PIPE cycles after the last issue).
REQ-013 DONE SHALL pulse done for one cycle, then return to IDLE; busy is high in RUN and DRAIN only.
REQ-014 tag_* SHALL equal the issued read's og/ig/last-ig/last delayed by exactly PIPE cycles; tag_valid equals rd_en delayed by PIPE.
REQ-015 start while busy SHALL be ignored.
REQ-016 Credits SHALL persist across jobs; they are not reset by start.

Reset
REQ-017 Asserting rst_n low, including mid-job, SHALL asynchronously clear to:
- FSM = IDLE.
- Counters and credit count = 0.
- Tag pipeline empty.
- All outputs 0.
REQ-018 After release, no read SHALL issue until a new start.

Configuration
REQ-019 With WRS_READY_CHECK_EN defined, an extra output err_sticky SHALL set (until reset) whenever data_ready differs from tag_valid.
REQ-020 With WRS_READY_CHECK_EN undefined, the port and its logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-021 Package weight_pkg SHALL hold the FSM state enum, the PIPE default and a tag struct {og, ig, last_ig, last}.
REQ-022 Sub-module wrs_tag_pipe SHALL be the PIPE-deep shift register carrying valid plus the tag struct.

Verification
REQ-023 co=2, ci=4, reps=1, CREDITS=8, credit_ret asserted every cycle from the first tag_valid:
- rd_addr 0..7 on consecutive cycles.
- tag_valid 3 cycles later; tag_last at og=1, ig=3.
- done pulses the cycle after the DRAIN→DONE transition.
REQ-024 co=1, ci=3, reps=2:
- rd_addr sequence 0,1,2,0,1,2.
- tag_last_ig high on both ig=2 reads.
REQ-025 CREDITS=2, credit_ret withheld for 10 cycles:
- Exactly 2 reads issue, then rd_en stays low and rd_addr holds.
- A single credit_ret allows exactly one further read.
REQ-026 start with ci=0:
- No rd_en.
- done pulses 2 cycles after start.
- busy never asserts.
REQ-027 rst_n low for 1 cycle mid-RUN at rd_addr=5:
- Outputs clear immediately.
- A following start with co=1, ci=2 issues addresses 0,1.
REQ-028 With WRS_READY_CHECK_EN defined, hold data_ready low on one tag_valid cycle:
- err_sticky sets and stays 1 until reset.
